// File: rtl/puf_host_link.sv
// puf_host_link: host-side bridge that shifts a challenge out to the PUF SoC and captures its response frame.
// Build option PUF_HOST_PARITY_EN adds o_resp_parity and flags odd-parity frames on o_error.
module puf_host_link #(
    parameter int REG_BIT_SIZE = 40,
    parameter int FRAM_SIZE    = 160,
    parameter int NORM_MOD     = 34,
    parameter int DEBUG_MOD    = 157,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic                           i_op_mode,
    input  logic [REG_BIT_SIZE-1:0]        i_challenge,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error,
    output logic [FRAM_SIZE-1:0]           o_resp_data,
    output logic [$clog2(FRAM_SIZE+1)-1:0] o_resp_len,
    output logic                           o_dut_rx_valid,
    output logic                           o_dut_rx_data,
    input  logic                           i_dut_rx_ready,
    output logic                           o_dut_tx_ready,
    input  logic                           i_dut_tx_valid,
    input  logic                           i_dut_tx_data
`ifdef PUF_HOST_PARITY_EN
    ,
    output logic                           o_resp_parity
`endif
);
    localparam int LW = $clog2(FRAM_SIZE + 1);
    localparam int CW = $clog2(REG_BIT_SIZE + FRAM_SIZE + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 2);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t                  state_q;
    logic [REG_BIT_SIZE-1:0] sr_q;
    logic                    mode_q;
    logic [CW-1:0]           cnt_q;
    logic [TW-1:0]           tmo_q;
    logic [TW-1:0]           tmo_d;
    logic                    valid_q, ready_q, busy_q, done_q, err_q, par_q, par_d;
    logic [FRAM_SIZE-1:0]    data_q;
    logic [LW-1:0]           len_q;
    logic                    rx_xfer, tx_xfer, expire, last;

    assign rx_xfer = valid_q & i_dut_rx_ready;
    assign tx_xfer = ready_q & i_dut_tx_valid;
    assign last    = cnt_q == CW'(1);
    assign tmo_d   = tmo_q + TW'(1);
    // A transfer always beats expiry because the branches below test the transfer first.
    assign expire  = (TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign par_d   = par_q ^ i_dut_tx_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            par_q   <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    sr_q    <= i_challenge;
                    mode_q  <= i_op_mode;
                    cnt_q   <= CW'(REG_BIT_SIZE);
                    tmo_q   <= '0;
                    data_q  <= '0;
                    len_q   <= '0;
                    err_q   <= 1'b0;
                    par_q   <= 1'b0;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= SEND;
                end
                SEND: if (rx_xfer) begin
                    sr_q  <= sr_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                    tmo_q <= '0;
                    if (last) begin
                        cnt_q   <= mode_q ? CW'(DEBUG_MOD) : CW'(NORM_MOD);
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= RECV;
                    end
                end else if (expire) begin
                    err_q   <= 1'b1;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    tmo_q <= tmo_d;
                end
                RECV: if (tx_xfer) begin
                    data_q <= {data_q[FRAM_SIZE-2:0], i_dut_tx_data};
                    len_q  <= len_q + LW'(1);
                    par_q  <= par_d;
                    cnt_q  <= cnt_q - CW'(1);
                    tmo_q  <= '0;
                    if (last) begin
`ifdef PUF_HOST_PARITY_EN
                        err_q   <= par_d;
`endif
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end else if (expire) begin
                    err_q   <= 1'b1;
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    tmo_q <= tmo_d;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = err_q;
    assign o_resp_data    = data_q;
    assign o_resp_len     = len_q;
    assign o_dut_rx_valid = valid_q;
    assign o_dut_rx_data  = valid_q & sr_q[REG_BIT_SIZE-1];
    assign o_dut_tx_ready = ready_q;
`ifdef PUF_HOST_PARITY_EN
    assign o_resp_parity  = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif
endmodule
